// File: rtl/id_addr_decode.sv
// Registered rule-table decoder: maps an address/ID to a target index via range or NAPOT rules.
// Optional simulation checks are enabled with the ID_ADDR_DECODE_ASSERT_EN macro.
module id_addr_decode #(
  parameter int NoIndices = 1,
  parameter int NoRules   = 1,
  parameter int AddrWidth = 32,
  parameter int Napot     = 0,
  localparam int IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1,
  localparam int RuleW    = IdxWidth + 2*AddrWidth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  input  logic [AddrWidth-1:0]       addr_i,
  input  logic [NoRules*RuleW-1:0]   addr_map_i,
  input  logic [IdxWidth-1:0]        default_idx_i,
  input  logic                       en_default_idx_i,
  output logic                       valid_o,
  output logic [IdxWidth-1:0]        idx_o,
  output logic                       dec_valid_o,
  output logic                       dec_error_o
);

  // In NAPOT mode the start field is the base and the end field is the mask.
  function automatic logic rule_match(input logic [AddrWidth-1:0] addr,
                                      input logic [AddrWidth-1:0] start_addr,
                                      input logic [AddrWidth-1:0] end_addr);
    if (Napot != 0)
      return (addr & end_addr) == (start_addr & end_addr);
    else
      return (addr >= start_addr) && ((addr < end_addr) || (end_addr == '0));
  endfunction

  logic                hit_p0;
  logic [IdxWidth-1:0] hit_idx_p0;
  logic [IdxWidth-1:0] idx_nxt_p0;
  logic                dec_valid_nxt_p0;
  logic                dec_error_nxt_p0;

  logic                vld_p1;
  logic [IdxWidth-1:0] idx_p1;
  logic                dec_valid_p1;
  logic                dec_error_p1;

  // Stage p0: rule evaluation; later rules override earlier ones.
  always_comb begin
    hit_p0     = 1'b0;
    hit_idx_p0 = '0;
    for (int r = 0; r < NoRules; r++) begin
      if (rule_match(addr_i,
                     addr_map_i[r*RuleW + AddrWidth +: AddrWidth],
                     addr_map_i[r*RuleW +: AddrWidth])) begin
        hit_p0     = 1'b1;
        hit_idx_p0 = addr_map_i[r*RuleW + 2*AddrWidth +: IdxWidth];
      end
    end
  end

  always_comb begin
    idx_nxt_p0       = '0;
    dec_valid_nxt_p0 = 1'b0;
    dec_error_nxt_p0 = 1'b0;
    if (hit_p0) begin
      idx_nxt_p0       = hit_idx_p0;
      dec_valid_nxt_p0 = 1'b1;
    end else if (en_default_idx_i) begin
      idx_nxt_p0       = default_idx_i;
    end else begin
      dec_error_nxt_p0 = 1'b1;
    end
  end

  // Stage p1: output registers; decode fields hold while no request is presented.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1       <= 1'b0;
      idx_p1       <= '0;
      dec_valid_p1 <= 1'b0;
      dec_error_p1 <= 1'b0;
    end else begin
      vld_p1 <= valid_i;
      if (valid_i) begin
        idx_p1       <= idx_nxt_p0;
        dec_valid_p1 <= dec_valid_nxt_p0;
        dec_error_p1 <= dec_error_nxt_p0;
      end
    end
  end

  assign valid_o     = vld_p1;
  assign idx_o       = idx_p1;
  assign dec_valid_o = dec_valid_p1;
  assign dec_error_o = dec_error_p1;

`ifdef ID_ADDR_DECODE_ASSERT_EN
  if (NoRules == 0 || NoIndices == 0) begin : g_param_chk
    $fatal(1, "id_addr_decode: NoRules and NoIndices must be non-zero");
  end

  always @(posedge clk_i) begin
    if (rst_ni && valid_i) begin : chk_blk
      int n_hit;
      n_hit = 0;
      for (int r = 0; r < NoRules; r++) begin
        if (int'(addr_map_i[r*RuleW + 2*AddrWidth +: IdxWidth]) >= NoIndices)
          $error("id_addr_decode: rule %0d idx out of range", r);
        if (Napot == 0 && addr_map_i[r*RuleW +: AddrWidth] != '0 &&
            addr_map_i[r*RuleW + AddrWidth +: AddrWidth] > addr_map_i[r*RuleW +: AddrWidth])
          $error("id_addr_decode: rule %0d start above end", r);
        if (rule_match(addr_i, addr_map_i[r*RuleW + AddrWidth +: AddrWidth],
                       addr_map_i[r*RuleW +: AddrWidth]))
          n_hit++;
      end
      if (n_hit > 1)
        $warning("id_addr_decode: %0d overlapping rules match address %0h", n_hit, addr_i);
    end
  end
`else
  // Synthesis builds carry no checking logic.
`endif

endmodule

// File: tb/tb_id_addr_decode.sv
// Self-checking bench for id_addr_decode: directed table, corner sequences and randomized
// traffic against a priority-search reference model, on a range and a NAPOT instance.
module tb_id_addr_decode;
  localparam int NI = 4;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int RW = IW + 2*AW;
  localparam int MW = NR*RW;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          dv;
    logic          de;
  } res_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          en;
    logic [IW-1:0] def;
    logic [IW-1:0] e_idx;
    logic          e_dv;
    logic          e_de;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [MW-1:0] map = '0;
  logic [IW-1:0] def = '0;
  logic          en = 1'b0;

  logic          r_vld, r_dv, r_de, n_vld, n_dv, n_de;
  logic [IW-1:0] r_idx, n_idx;

  int errors = 0;
  int checks = 0;

  logic exp_vld;
  res_t exp_r, exp_n;

  always #5 clk = ~clk;

  id_addr_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(0)) dut_rng (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .addr_i(addr), .addr_map_i(map),
    .default_idx_i(def), .en_default_idx_i(en), .valid_o(r_vld), .idx_o(r_idx),
    .dec_valid_o(r_dv), .dec_error_o(r_de));

  id_addr_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(1)) dut_npt (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .addr_i(addr), .addr_map_i(map),
    .default_idx_i(def), .en_default_idx_i(en), .valid_o(n_vld), .idx_o(n_idx),
    .dec_valid_o(n_dv), .dec_error_o(n_de));

  // Reference: scan from the highest rule down, first match wins.
  function automatic res_t ref_decode(input bit napot, input logic [AW-1:0] a,
                                      input logic [MW-1:0] m, input logic en_d,
                                      input logic [IW-1:0] d);
    res_t res;
    logic [RW-1:0] rule;
    logic [AW-1:0] s, e;
    bit hit;
    for (int r = NR-1; r >= 0; r--) begin
      rule = m[r*RW +: RW];
      s = rule[2*AW-1:AW];
      e = rule[AW-1:0];
      if (napot) hit = ((a & e) == (s & e));
      else       hit = (a >= s) && (e == 0 || a < e);
      if (hit) begin
        res.idx = rule[RW-1:2*AW];
        res.dv = 1'b1;
        res.de = 1'b0;
        return res;
      end
    end
    res.idx = en_d ? d : '0;
    res.dv  = 1'b0;
    res.de  = !en_d;
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_rule(input int r, input logic [IW-1:0] idx,
                          input logic [AW-1:0] s, input logic [AW-1:0] e);
    map[r*RW +: RW] = {idx, s, e};
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rng valid_o"}, 32'(r_vld), 32'(exp_vld));
    chk({tag, " rng idx_o"},   32'(r_idx), 32'(exp_r.idx));
    chk({tag, " rng dec_valid"}, 32'(r_dv), 32'(exp_r.dv));
    chk({tag, " rng dec_error"}, 32'(r_de), 32'(exp_r.de));
    chk({tag, " npt valid_o"}, 32'(n_vld), 32'(exp_vld));
    chk({tag, " npt idx_o"},   32'(n_idx), 32'(exp_n.idx));
    chk({tag, " npt dec_valid"}, 32'(n_dv), 32'(exp_n.dv));
    chk({tag, " npt dec_error"}, 32'(n_de), 32'(exp_n.de));
  endtask

  // One clock edge; the model tracks the registered outputs for both instances.
  task automatic step(input bit use_model, input string tag);
    res_t nr, nn;
    nr = ref_decode(1'b0, addr, map, en, def);
    nn = ref_decode(1'b1, addr, map, en, def);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_vld = 1'b0;
      exp_r = '0;
      exp_n = '0;
    end else begin
      exp_vld = valid;
      if (valid) begin
        exp_r = nr;
        exp_n = nn;
      end
    end
    if (use_model) check_model(tag);
  endtask

  vec_t vecs[11];

  initial begin
    exp_vld = 1'b0;
    exp_r = '0;
    exp_n = '0;
    vecs[0]  = '{32'h1000, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{32'h2FFF, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{32'h1850, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0};
    vecs[3]  = '{32'h3000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{32'h3000, 1'b0, 2'd2, 2'd0, 1'b0, 1'b1};
    vecs[5]  = '{32'h3000, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0};
    vecs[6]  = '{32'h0FFF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'h1FFF, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{32'h1900, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{32'h18FF, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{32'h2000, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0};

    // Reset state with a request presented during reset.
    rst_n = 1'b0;
    valid = 1'b1;
    addr = 32'h1000;
    set_rule(0, 2'd1, 32'h1000, 32'h2000);
    set_rule(1, 2'd2, 32'h2000, 32'h3000);
    set_rule(2, 2'd3, 32'h1800, 32'h1900);
    en = 1'b1;
    step(1'b0, "rst");
    step(1'b0, "rst");
    chk("reset valid_o", 32'(r_vld), 32'd0);
    chk("reset idx_o", 32'(r_idx), 32'd0);
    chk("reset dec_valid", 32'(r_dv), 32'd0);
    chk("reset dec_error", 32'(r_de), 32'd0);
    chk("reset npt valid_o", 32'(n_vld), 32'd0);
    rst_n = 1'b1;

    // Range-mode table.
    for (int i = 0; i < 11; i++) begin
      valid = 1'b1;
      addr  = vecs[i].addr;
      en    = vecs[i].en;
      def   = vecs[i].def;
      step(1'b0, "tbl");
      chk($sformatf("tbl%0d valid_o", i), 32'(r_vld), 32'd1);
      chk($sformatf("tbl%0d idx_o", i), 32'(r_idx), 32'(vecs[i].e_idx));
      chk($sformatf("tbl%0d dec_valid", i), 32'(r_dv), 32'(vecs[i].e_dv));
      chk($sformatf("tbl%0d dec_error", i), 32'(r_de), 32'(vecs[i].e_de));
    end

    // Open-ended rule reaches the top of the address space.
    set_rule(1, 2'd2, 32'h2000, 32'h0);
    addr = 32'hFFFF_FFFF;
    en = 1'b0;
    step(1'b0, "open");
    chk("open idx_o", 32'(r_idx), 32'd2);
    chk("open dec_valid", 32'(r_dv), 32'd1);
    chk("open dec_error", 32'(r_de), 32'd0);

    // Empty range (start == end) never matches.
    set_rule(1, 2'd2, 32'h5000, 32'h5000);
    addr = 32'h5000;
    step(1'b0, "empty");
    chk("empty dec_error", 32'(r_de), 32'd1);
    chk("empty idx_o", 32'(r_idx), 32'd0);

    // NAPOT instance.
    set_rule(0, 2'd2, 32'h4000, 32'hFFFF_F000);
    set_rule(1, 2'd1, 32'hDEAD_0000, 32'hFFFF_FFFF);
    set_rule(2, 2'd3, 32'h0, 32'hFFFF_FFFF);
    addr = 32'h4ABC;
    step(1'b0, "napot");
    chk("napot hit idx_o", 32'(n_idx), 32'd2);
    chk("napot hit dec_valid", 32'(n_dv), 32'd1);
    addr = 32'h5000;
    step(1'b0, "napot");
    chk("napot miss dec_error", 32'(n_de), 32'd1);
    chk("napot miss dec_valid", 32'(n_dv), 32'd0);
    set_rule(2, 2'd3, 32'h1234_5678, 32'h0);
    addr = 32'h4ABC;
    step(1'b0, "napot");
    chk("napot mask0 idx_o", 32'(n_idx), 32'd3);
    chk("napot mask0 dec_valid", 32'(n_dv), 32'd1);

    // Reset mid-stream, then one request followed by idle cycles.
    set_rule(0, 2'd1, 32'h1000, 32'h2000);
    set_rule(1, 2'd2, 32'h2000, 32'h3000);
    set_rule(2, 2'd3, 32'h1800, 32'h1900);
    rst_n = 1'b0;
    valid = 1'b1;
    addr = 32'h1000;
    step(1'b0, "rst2");
    chk("rst2 valid_o", 32'(r_vld), 32'd0);
    chk("rst2 idx_o", 32'(r_idx), 32'd0);
    chk("rst2 dec_valid", 32'(r_dv), 32'd0);
    rst_n = 1'b1;
    addr = 32'h2500;
    step(1'b0, "pulse");
    chk("pulse valid_o", 32'(r_vld), 32'd1);
    chk("pulse idx_o", 32'(r_idx), 32'd2);
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h3000 + 32'(i);
      en = 1'b0;
      step(1'b0, "hold");
      chk("hold valid_o", 32'(r_vld), 32'd0);
      chk("hold idx_o", 32'(r_idx), 32'd2);
      chk("hold dec_valid", 32'(r_dv), 32'd1);
      chk("hold dec_error", 32'(r_de), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        for (int r = 0; r < NR; r++) begin
          logic [AW-1:0] s, e;
          s = $urandom_range(0, 32'hFFFF);
          case ($urandom_range(0, 7))
            0:       e = '0;
            1:       e = s;
            2:       e = s - $urandom_range(1, 16'h100);
            3:       e = 32'hFFFF_0000 | ~((32'd1 << $urandom_range(0, 15)) - 1);
            default: e = s + $urandom_range(1, 16'h3000);
          endcase
          set_rule(r, IW'($urandom_range(0, 3)), s, e);
        end
      end
      rst_n = ($urandom_range(0, 49) != 0);
      valid = ($urandom_range(0, 3) != 0);
      en    = $urandom_range(0, 1);
      def   = IW'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: addr = $urandom;
        1: addr = $urandom_range(0, 32'hFFFF);
        default: addr = map[$urandom_range(0, NR-1)*RW + AW +: AW] + $urandom_range(0, 16'h400);
      endcase
      step(1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_addr_decode.md
Name: id_addr_decode

Overview:
- Registered rule-table decoder: maps an address/ID to a target index by matching it against a runtime-programmable rule table.
- Used by NoC routers to turn a flit's destination ID into an output-port index, and by crossbars to pick a slave port.
- Supports range rules or NAPOT (base/mask) rules.
- Has a default-index fallback and reports a one-cycle-latency decode result.

Parameters:
- NoIndices, 1: number of legal target indices; IdxWidth = max(1, clog2(NoIndices)).
- NoRules, 1: number of rules in the table (>=1).
- AddrWidth, 32: width of the address/ID and of the rule start/end fields.
- Napot, 0: 0 = range rules; 1 = NAPOT base/mask rules.

Ports:
- clk_i  input  1  clock, all state on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- valid_i  input  1  a decode request is presented this cycle.
- addr_i  input  AddrWidth  address/ID to decode.
- addr_map_i  input  NoRules*(IdxWidth+2*AddrWidth)  rule table. Rule r occupies bits [r*RW +: RW], RW = IdxWidth+2*AddrWidth. Fields MSB to LSB: idx, start_addr, end_addr.
- default_idx_i  input  IdxWidth  fallback index.
- en_default_idx_i  input  1  enable the fallback on a miss.
- valid_o  output  1  registered copy of valid_i.
- idx_o  output  IdxWidth  decoded index.
- dec_valid_o  output  1  at least one rule matched.
- dec_error_o  output  1  no rule matched and the default is disabled.

Behaviour:
- One clock; reset is synchronous and active-low. All outputs come from flops.
- Reset (rst_ni=0 at a clock edge): valid_o=0, idx_o=0, dec_valid_o=0, dec_error_o=0. Reset dominates valid_i in the same cycle. A request in flight when reset is applied is dropped.
- Latency: a request sampled at edge N appears on the outputs after edge N, i.e. one cycle later.
  - valid_o follows valid_i every cycle; no backpressure, throughput one decode per cycle.
  - When valid_i=0, idx_o, dec_valid_o and dec_error_o hold their previous values.
- Match rule, range mode (Napot=0): rule r matches when addr >= start_addr and (addr < end_addr, or end_addr == 0).
  - end_addr == 0 means "up to the top of the address space".
  - start_addr == end_addr != 0 never matches.
- Match rule, NAPOT mode (Napot=1): start_addr is the base, end_addr is the mask. Rule matches when (addr & mask) == (base & mask).
  - mask = 0 matches every address.
- Priority: when several rules match, the highest-numbered rule wins (rules are evaluated 0..NoRules-1 and each later match overrides).
- On any match: dec_valid_o=1, dec_error_o=0, idx_o = winning rule's idx field.
  - The idx field is passed through unchanged even if it is >= NoIndices.
- No match, en_default_idx_i=1: idx_o=default_idx_i, dec_valid_o=0, dec_error_o=0.
- No match, en_default_idx_i=0: idx_o=0, dec_valid_o=0, dec_error_o=1.
- dec_valid_o and dec_error_o are never both 1.
- addr_map_i, default_idx_i and en_default_idx_i are sampled in the same cycle as valid_i; changing the table affects the next request only.
- The comparison logic is pure combinational from inputs to the output flops; no other internal state.

Optional Feature:
- Macro: ID_ADDR_DECODE_ASSERT_EN.
- Defined: add simulation-only checks, evaluated on each clock edge with valid_i=1 and rst_ni=1.
  - $error if any rule's idx >= NoIndices.
  - $error in range mode if end_addr != 0 and start_addr > end_addr.
  - $warning if two rules overlap for the presented address, i.e. more than one match.
  - $fatal at elaboration if NoRules == 0 or NoIndices == 0.
- Undefined: no checks compiled in; functional behaviour identical.

Test Plan:
- Common setup: AddrWidth=32, NoIndices=4, NoRules=3.
  - r0 = {idx 1, 0x1000, 0x2000}
  - r1 = {idx 2, 0x2000, 0x3000}
  - r2 = {idx 3, 0x1800, 0x1900}
- Match: addr 0x1000 -> next cycle idx_o=1, dec_valid_o=1, dec_error_o=0, valid_o=1. Addr 0x2FFF -> idx_o=2.
- Overlap: addr 0x1850 -> idx_o=3, since highest rule wins.
- Miss: addr 0x3000.
  - en_default=1, default_idx=0 -> idx_o=0, dec_valid_o=0, dec_error_o=0.
  - en_default=0 -> dec_error_o=1, idx_o=0.
- Open end: set r1.end_addr=0, addr 0xFFFF_FFFF -> idx_o=2, dec_valid_o=1.
- NAPOT (Napot=1): rule {idx 2, base 0x4000, mask 0xFFFF_F000}.
  - Addr 0x4ABC -> idx_o=2.
  - Addr 0x5000 with default disabled -> dec_error_o=1.
- Reset/hold: drive valid_i=1 with rst_ni=0 -> all outputs 0. Release reset and pulse one request, then hold valid_i=0 -> outputs keep the last decode while valid_o returns to 0.
